// File: rtl/mux2_arbiter_if.sv
// Handshake and data bundle between two requesters and the mux2_arbiter.
// The master side drives requests and data; the slave side is the arbiter.
interface mux2_arbiter_if #(
    parameter int WIDTH = 1
);
    logic             req_a;
    logic             req_b;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             gnt_a;
    logic             gnt_b;
    logic             s;
    logic [WIDTH-1:0] y;
    logic             y_valid;

    modport master (
        output req_a, req_b, a, b,
        input  gnt_a, gnt_b, s, y, y_valid
    );

    modport slave (
        input  req_a, req_b, a, b,
        output gnt_a, gnt_b, s, y, y_valid
    );
endinterface

// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter with bounded bursts, driving a registered 2:1 mux.
// Grant/select come from the FSM register; data appears one cycle after a grant cycle.
module mux2_arbiter #(
    parameter int WIDTH     = 1,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst,
    mux2_arbiter_if.slave  bus
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             last_b_q;
    logic             last_b_d;
    logic             s_q;
    logic             s_d;
    logic             grant_any;
    logic [WIDTH-1:0] y_p1;
    logic             vld_p1;

    // last_b_q resets to 1 so that a simultaneous first request goes to A
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_b_q <= 1'b1;
            s_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_b_q <= last_b_d;
            s_q      <= s_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_b_d = last_b_q;
        s_d      = s_q;

        case (state_q)
            IDLE: begin
                if (bus.req_a && bus.req_b) begin
                    state_d = last_b_q ? OWN_A : OWN_B;
                end else if (bus.req_a) begin
                    state_d = OWN_A;
                end else if (bus.req_b) begin
                    state_d = OWN_B;
                end
            end
            OWN_A: begin
                if (!bus.req_a) begin
                    state_d = bus.req_b ? OWN_B : IDLE;
                end else if (bus.req_b && (cnt_q == CNT_SAT)) begin
                    state_d = OWN_B;
                end
            end
            OWN_B: begin
                if (!bus.req_b) begin
                    state_d = bus.req_a ? OWN_A : IDLE;
                end else if (bus.req_a && (cnt_q == CNT_SAT)) begin
                    state_d = OWN_A;
                end
            end
            default: state_d = IDLE;
        endcase

        // Entering an owner state restarts the burst; staying counts up to saturation
        if ((state_d != IDLE) && (state_d != state_q)) begin
            cnt_d    = '0;
            last_b_d = (state_d == OWN_B);
            s_d      = (state_d == OWN_B);
        end else if ((state_d != IDLE) && (cnt_q != CNT_SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign grant_any = (state_q == OWN_A) || (state_q == OWN_B);

    // Data stage p1: sample the granted requester one cycle behind the grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            y_p1   <= '0;
        end else begin
            vld_p1 <= grant_any;
            if (grant_any) begin
                y_p1 <= s_q ? bus.b : bus.a;
            end
        end
    end

    assign bus.gnt_a   = (state_q == OWN_A);
    assign bus.gnt_b   = (state_q == OWN_B);
    assign bus.s       = s_q;
    assign bus.y       = y_p1;
    assign bus.y_valid = vld_p1;

`ifndef SYNTHESIS
    a_grant_excl: assert property (@(posedge clk) disable iff (rst)
        !(bus.gnt_a && bus.gnt_b));
    a_sel_a: assert property (@(posedge clk) disable iff (rst)
        bus.gnt_a |-> !bus.s);
    a_sel_b: assert property (@(posedge clk) disable iff (rst)
        bus.gnt_b |-> bus.s);
`endif

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench for mux2_arbiter: a cycle model pushes expected outputs as stimulus
// is driven; each scenario task pops and compares after the edge, plus directed checks.
module tb_mux2_arbiter;

    localparam int WIDTH = 1;
    localparam int MB    = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mux2_arbiter_if #(.WIDTH(WIDTH)) bus ();
    mux2_arbiter_if #(.WIDTH(WIDTH)) bus1 ();

    mux2_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mux2_arbiter #(.WIDTH(WIDTH), .MAX_BURST(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    assign bus1.req_a = bus.req_a;
    assign bus1.req_b = bus.req_b;
    assign bus1.a     = bus.a;
    assign bus1.b     = bus.b;

    typedef struct packed {
        logic             gnt_a;
        logic             gnt_b;
        logic             s;
        logic             y_valid;
        logic [WIDTH-1:0] y;
    } obs_t;

    obs_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    int               m_st;
    int               m_cnt;
    bit               m_last_b;
    logic             m_s;
    logic [WIDTH-1:0] m_y;
    logic             m_vld;

    function automatic obs_t observe();
        obs_t o;
        o.gnt_a   = bus.gnt_a;
        o.gnt_b   = bus.gnt_b;
        o.s       = bus.s;
        o.y_valid = bus.y_valid;
        o.y       = bus.y;
        return o;
    endfunction

    task automatic model_reset();
        m_st     = 0;
        m_cnt    = 0;
        m_last_b = 1'b1;
        m_s      = 1'b0;
        m_y      = '0;
        m_vld    = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle of stimulus, advance the reference model, queue the expectation
    task automatic cycle(input logic ra, input logic rb,
                         input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db);
        int   nst;
        obs_t e;
        @(negedge clk);
        bus.req_a = ra;
        bus.req_b = rb;
        bus.a     = da;
        bus.b     = db;
        m_vld = (m_st != 0);
        if (m_st != 0) m_y = m_s ? db : da;
        nst = m_st;
        if (m_st == 0) begin
            if (ra && rb)  nst = m_last_b ? 1 : 2;
            else if (ra)   nst = 1;
            else if (rb)   nst = 2;
        end else if (m_st == 1) begin
            if (!ra)                         nst = rb ? 2 : 0;
            else if (rb && m_cnt == MB - 1)  nst = 2;
        end else begin
            if (!rb)                         nst = ra ? 1 : 0;
            else if (ra && m_cnt == MB - 1)  nst = 1;
        end
        if (nst != 0 && nst != m_st) begin
            m_cnt    = 0;
            m_last_b = (nst == 2);
            m_s      = (nst == 2);
        end else if (nst != 0 && m_cnt < MB - 1) begin
            m_cnt = m_cnt + 1;
        end
        m_st = nst;
        e.gnt_a   = (m_st == 1);
        e.gnt_b   = (m_st == 2);
        e.s       = m_s;
        e.y_valid = m_vld;
        e.y       = m_y;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        obs_t got;
        #2;
        got = observe();
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", got);
        end
        do_reset();
    endtask

    task automatic test_basic();
        obs_t exp, got;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0);
            exp = sb.pop_front();
            got = observe();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL basic_sb cyc=%0d got=%b exp=%b", i, got, exp);
            end
            checks++;
            if (bus.gnt_a !== 1'b1 || bus.s !== 1'b0 || bus.y_valid !== (i > 0) ||
                (i > 0 && bus.y !== 1'b1)) begin
                failures++;
                $display("FAIL basic_dir cyc=%0d gnt_a=%b s=%b vld=%b y=%b",
                         i, bus.gnt_a, bus.s, bus.y_valid, bus.y);
            end
        end
    endtask

    task automatic test_contention();
        obs_t exp, got;
        logic [WIDTH-1:0] da, db;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            da = WIDTH'($urandom_range(0, 1));
            db = WIDTH'($urandom_range(0, 1));
            cycle(1'b1, 1'b1, da, db);
            exp = sb.pop_front();
            got = observe();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL contend_sb cyc=%0d got=%b exp=%b", i, got, exp);
            end
            checks++;
            if (bus.gnt_a !== ((i / 4) % 2 == 0) || bus.gnt_b !== ((i / 4) % 2 == 1)) begin
                failures++;
                $display("FAIL contend_burst cyc=%0d gnt_a=%b gnt_b=%b", i, bus.gnt_a, bus.gnt_b);
            end
            checks++;
            if (bus1.gnt_a !== (i % 2 == 0) || bus1.gnt_b !== (i % 2 == 1)) begin
                failures++;
                $display("FAIL burst1_alt cyc=%0d gnt_a=%b gnt_b=%b", i, bus1.gnt_a, bus1.gnt_b);
            end
        end
    endtask

    task automatic test_uncontested();
        obs_t exp, got;
        logic [31:0] iv;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            iv = 32'(i);
            cycle(1'b1, 1'b0, WIDTH'(iv[0]), 1'b0);
            exp = sb.pop_front();
            got = observe();
            checks++;
            if (got !== exp || bus.gnt_a !== 1'b1) begin
                failures++;
                $display("FAIL uncontested cyc=%0d got=%b exp=%b", i, got, exp);
            end
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        exp = sb.pop_front();
        got = observe();
        checks++;
        if (got !== exp || bus.gnt_b !== 1'b1 || bus.gnt_a !== 1'b0) begin
            failures++;
            $display("FAIL sat_handover got=%b exp=%b", got, exp);
        end
    endtask

    task automatic test_handover();
        obs_t exp, got;
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        void'(sb.pop_front());
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        exp = sb.pop_front();
        got = observe();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL handover_pre got=%b exp=%b", got, exp);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        exp = sb.pop_front();
        got = observe();
        checks++;
        if (got !== exp || bus.gnt_b !== 1'b1 || bus.gnt_a !== 1'b0 || bus.s !== 1'b1) begin
            failures++;
            $display("FAIL handover_direct got=%b exp=%b", got, exp);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        exp = sb.pop_front();
        got = observe();
        checks++;
        if (got !== exp || bus.y !== 1'b1 || bus.y_valid !== 1'b1) begin
            failures++;
            $display("FAIL handover_data got=%b exp=%b", got, exp);
        end
    endtask

    task automatic test_fairness();
        obs_t exp, got;
        do_reset();
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        void'(sb.pop_front());
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        exp = sb.pop_front();
        got = observe();
        checks++;
        if (got !== exp || bus.gnt_a !== 1'b0 || bus.gnt_b !== 1'b0) begin
            failures++;
            $display("FAIL fair_idle got=%b exp=%b", got, exp);
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        exp = sb.pop_front();
        got = observe();
        checks++;
        if (got !== exp || bus.gnt_b !== 1'b1 || bus.gnt_a !== 1'b0) begin
            failures++;
            $display("FAIL fair_pointer got=%b exp=%b", got, exp);
        end
    endtask

    task automatic test_rst_mid();
        obs_t exp, got;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b1);
            exp = sb.pop_front();
            got = observe();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL rst_mid_pre cyc=%0d got=%b exp=%b", i, got, exp);
            end
        end
        #1 rst = 1'b1;
        #1;
        got = observe();
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL rst_async got=%b exp=0", got);
        end
        #1 rst = 1'b0;
        model_reset();
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        exp = sb.pop_front();
        got = observe();
        checks++;
        if (got !== exp || bus.gnt_b !== 1'b1 || bus.y_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_post got=%b exp=%b", got, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        model_reset();
        test_reset();
        test_basic();
        test_contention();
        test_uncontested();
        test_handover();
        test_fairness();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 Parameter WIDTH, default 1: data width of each requester input and of y.
REQ-002 Parameter MAX_BURST, default 4, legal range >= 1: maximum consecutive grant cycles while the other side is requesting.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_a  input  1  requester A asks for the shared output.
REQ-006 req_b  input  1  requester B asks for the shared output.
REQ-007 a  input  WIDTH  requester A data.
REQ-008 b  input  WIDTH  requester B data.
REQ-009 gnt_a  output  1  A owns the output; registered.
REQ-010 gnt_b  output  1  B owns the output; registered.
REQ-011 s  output  1  mux select, 0 = A, 1 = B; registered.
REQ-012 y  output  WIDTH  registered shared output data.
REQ-013 y_valid  output  1  y holds data sampled during a grant cycle.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, OWN_A, OWN_B.
REQ-015 gnt_a SHALL be 1 iff the state is OWN_A, and gnt_b SHALL be 1 iff the state is OWN_B; both SHALL never be 1 together.
REQ-016 A priority pointer SHALL record the last owner; after reset it SHALL favour A.
REQ-017 IDLE transitions:
- neither req -> stay in IDLE.
- only req_a -> OWN_A.
- only req_b -> OWN_B.
- both -> the side not last served.
REQ-018 OWN_A transitions (OWN_B is symmetric):
- req_a=0 and req_b=1 -> OWN_B.
- req_a=0 and req_b=0 -> IDLE.
- req_a=1, req_b=1 and burst count = MAX_BURST-1 -> OWN_B.
- otherwise -> stay in OWN_A.
REQ-019 The burst counter SHALL clear to 0 on entry to any OWN state and increment each cycle the state stays.
REQ-020 The burst counter SHALL saturate at MAX_BURST-1.
REQ-021 An uncontested owner SHALL keep the grant indefinitely. If the other side then requests while the counter is saturated, handover SHALL occur at the next edge.
REQ-022 An OWN_A <-> OWN_B handover SHALL be direct, with no IDLE cycle in between.
REQ-023 The pointer SHALL update to the new owner on every entry to an OWN state.
REQ-024 s SHALL be 0 in OWN_A and 1 in OWN_B, and SHALL hold its last value in IDLE.
REQ-025 Data SHALL have 1-cycle latency. At each edge:
- y_valid <= gnt_a | gnt_b.
- y <= (s ? b : a) when a grant is active; otherwise y holds.
REQ-026 With MAX_BURST=1 and both sides requesting continuously, grants SHALL alternate every cycle.
REQ-027 Requests SHALL be level-sensitive; the block SHALL not latch a request that drops before it is granted.

Reset
REQ-028 While rst=1 the block SHALL immediately, without a clock edge, force:
- state IDLE;
- gnt_a=0, gnt_b=0, s=0, y=0, y_valid=0;
- burst counter 0;
- pointer favouring A.
REQ-029 Assertion of rst mid-burst SHALL abort the grant. After release, the first edge SHALL evaluate from IDLE per REQ-017.

Verification
REQ-030 Bench SHALL cover these directed scenarios (MAX_BURST=4, WIDTH=1):
- Reset release, then req_a=1, a=1 -> gnt_a=1 after edge 1; y_valid=1, y=1 after edge 2; s=0 throughout.
- req_a=req_b=1 held from IDLE after reset -> gnt_a for 4 cycles, then gnt_b for 4 cycles, repeating; s toggles each handover; no cycle with both grants or neither grant.
- req_a alone for 10 cycles, then req_b rises -> gnt_a held all 10 cycles; gnt_b=1 one edge after req_b rises.
- In OWN_A at count 1, req_a drops with req_b=1 -> next edge gnt_b=1, gnt_a=0, with no IDLE cycle; y follows b one cycle later.
- A served then both drop to IDLE; both re-request -> B wins (pointer fairness).
- rst pulsed mid-burst between clock edges -> gnt_a, gnt_b, s, y, y_valid all 0 before the next edge; after release with req_b only -> gnt_b after the first edge.
